// File: rtl/imem_port.sv
// imem_port: direct-mapped instruction cache answering fetch PCs, refilling 16-byte lines beat by beat
// clk/reset(async, active-low); req_valid/req_pc/flush from fetch; resp_valid/resp_pc/resp_instr and
// pc_write back to fetch; mem_req/mem_addr out and mem_valid/mem_data in for line refills.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
module imem_port #(
  parameter int ADDR_SIZE = `ADDR_SIZE,
  parameter int LINES     = 16,
  parameter int WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE-1:0] req_pc,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [ADDR_SIZE-1:0] resp_pc,
  output logic [31:0]          resp_instr,
  output logic                 pc_write,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_data
);
  localparam int IW = $clog2(LINES);
  localparam int LW = ADDR_SIZE - 4;
  localparam int TW = LW - IW;
  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;
  state_t                    state_q, state_d;
  logic [LINES-1:0]          valid_q;
  logic [TW-1:0]             tag_q  [LINES];
  logic [WORDS-1:0][31:0]    data_q [LINES];
  logic [WORDS-1:0][31:0]    lbuf_q;
  logic [LW-1:0]             line_q;
  logic [1:0]                off_q, beat_q;
  logic                      kill_q, resp_valid_q;
  logic [ADDR_SIZE-1:0]      resp_pc_q;
  logic [31:0]               resp_instr_q;
  logic [IW-1:0]             idx;
  logic [1:0]                off;
  logic [TW-1:0]             tag;
  logic                      lookup, hit, miss, last, unused_pc;
  assign idx       = req_pc[3+IW:4];
  assign off       = req_pc[3:2];
  assign tag       = req_pc[ADDR_SIZE-1:4+IW];
  assign unused_pc = ^req_pc[1:0];
  assign lookup    = req_valid & !flush & (state_q == IDLE);
  assign hit       = lookup & valid_q[idx] & (tag_q[idx] == tag);
  assign miss      = lookup & !hit;
  assign last      = (state_q == REFILL) & mem_valid & (beat_q == 2'd3);
  always_comb begin
    state_d = (state_q == IDLE)   ? (miss ? REFILL : IDLE) :
              (state_q == REFILL) ? (last ? RESPOND : REFILL) : IDLE;
  end
  assign mem_req    = state_q == REFILL;
  assign mem_addr   = mem_req ? {line_q, beat_q, 2'b00} : '0;
  // PC may advance again in RESPOND so fetch presents the next PC once back in IDLE
  assign pc_write   = (state_q != REFILL) & !miss;
  // a refill response is combinational so a flush in the RESPOND cycle can still suppress it
  assign resp_valid = resp_valid_q | ((state_q == RESPOND) & !kill_q & !flush);
  assign resp_pc    = resp_pc_q;
  assign resp_instr = resp_instr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      lbuf_q       <= '0;
      line_q       <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      resp_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= hit;
      if (hit) begin
        resp_pc_q    <= {req_pc[ADDR_SIZE-1:2], 2'b00};
        resp_instr_q <= data_q[idx][off];
      end
      if (miss) begin
        line_q <= req_pc[ADDR_SIZE-1:4];
        off_q  <= off;
        beat_q <= '0;
      end
      if (mem_req & mem_valid) begin
        lbuf_q[beat_q] <= mem_data;
        beat_q         <= beat_q + 2'd1;
      end
      if (last) begin
        valid_q[line_q[IW-1:0]] <= 1'b1;
        resp_pc_q               <= {line_q, off_q, 2'b00};
        resp_instr_q            <= (off_q == 2'd3) ? mem_data : lbuf_q[off_q];
      end
      // beats cannot be cancelled, so a redirect during refill only marks the response dead
      kill_q <= (state_q == RESPOND) ? 1'b0 : kill_q | (mem_req & flush);
    end
  end
  always_ff @(posedge clk) begin
    if (last) begin
      tag_q[line_q[IW-1:0]]  <= line_q[LW-1:IW];
      data_q[line_q[IW-1:0]] <= {mem_data, lbuf_q[2], lbuf_q[1], lbuf_q[0]};
    end
  end
endmodule

// File: tb/tb_imem_port.sv
// tb_imem_port: directed self-checking bench for imem_port
module tb_imem_port;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_instr;
  logic        pc_write;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  int          checks = 0;
  int          errors = 0;
  imem_port #(.ADDR_SIZE(32), .LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc), .flush(flush),
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr), .pc_write(pc_write),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rv, input logic [31:0] pc, input logic fl, input logic mv, input logic [31:0] md);
    @(negedge clk);
    req_valid = rv;
    req_pc    = pc;
    flush     = fl;
    mem_valid = mv;
    mem_data  = md;
    #1;
  endtask
  task automatic miss_seq(input logic [31:0] pc, input logic [31:0] d0, input bit slow, input int fl_at, input logic exp_v);
    logic [31:0] base;
    int k;
    base = pc & 32'hFFFF_FFF0;
    k = 0;
    step(1'b1, pc, 1'b0, 1'b0, 0);
    chk("miss_pcw", pc_write, 0);
    chk("miss_mreq", mem_req, 0);
    for (int b = 0; b < 4; b++) begin
      if (slow) begin
        k++;
        step(1'b0, pc, k == fl_at, 1'b0, 0);
        chk("gap_addr", mem_addr, base + 4 * b);
        chk("gap_pcw", pc_write, 0);
        chk("gap_rv", resp_valid, 0);
      end
      k++;
      step(1'b0, pc, k == fl_at, 1'b1, d0 + b);
      chk("beat_addr", mem_addr, base + 4 * b);
      chk("beat_mreq", mem_req, 1);
      chk("beat_pcw", pc_write, 0);
      chk("beat_rv", resp_valid, 0);
    end
    k++;
    step(1'b0, pc, k == fl_at, 1'b0, 0);
    chk("resp_v", resp_valid, exp_v);
    chk("resp_mreq", mem_req, 0);
    chk("resp_pcw", pc_write, 1);
    if (exp_v) begin
      chk("resp_pc", resp_pc, pc & 32'hFFFF_FFFC);
      chk("resp_instr", resp_instr, d0 + pc[3:2]);
    end
    step(1'b0, 0, 1'b0, 1'b0, 0);
    chk("after_rv", resp_valid, 0);
  endtask
  task automatic hit(input logic [31:0] pc, input logic [31:0] exp);
    step(1'b1, pc, 1'b0, 1'b0, 0);
    chk("hit_pcw", pc_write, 1);
    chk("hit_mreq", mem_req, 0);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    chk("hit_rv", resp_valid, 1);
    chk("hit_pc", resp_pc, pc & 32'hFFFF_FFFC);
    chk("hit_instr", resp_instr, exp);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rv", resp_valid, 0);
    chk("rst_pc", resp_pc, 0);
    chk("rst_instr", resp_instr, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_pcw", pc_write, 1);
    reset = 1'b1;
    miss_seq(32'h0, 32'h10, 1'b0, 0, 1'b1);
    miss_seq(32'h100, 32'hA0, 1'b0, 0, 1'b1);
    hit(32'h108, 32'hA2);
    hit(32'h10C, 32'hA3);
    miss_seq(32'h418, 32'hB0, 1'b1, 0, 1'b1);
    hit(32'h410, 32'hB0);
    miss_seq(32'h200, 32'hC0, 1'b0, 0, 1'b1);
    miss_seq(32'h100, 32'hD0, 1'b0, 0, 1'b1);
    miss_seq(32'h300, 32'hE0, 1'b0, 2, 1'b0);
    hit(32'h304, 32'hE1);
    miss_seq(32'h428, 32'hF0, 1'b0, 5, 1'b0);
    hit(32'h424, 32'hF1);
    step(1'b1, 32'h304, 1'b1, 1'b0, 0);
    chk("flush_req_pcw", pc_write, 1);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    chk("flush_req_rv", resp_valid, 0);
    step(1'b1, 32'h100, 1'b0, 1'b0, 0);
    chk("mid_miss_pcw", pc_write, 0);
    step(1'b0, 32'h100, 1'b0, 1'b1, 32'h77);
    step(1'b0, 32'h100, 1'b0, 1'b1, 32'h78);
    chk("mid_mreq_before", mem_req, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_mreq", mem_req, 0);
    chk("mid_rst_maddr", mem_addr, 0);
    chk("mid_rst_pcw", pc_write, 1);
    chk("mid_rst_rv", resp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    miss_seq(32'h100, 32'h50, 1'b0, 0, 1'b1);
    miss_seq(32'h414, 32'h60, 1'b0, 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
